// File: rtl/gray_pkg.sv
// +--------------------------------------------------------------------+
// | gray_pkg : shared Gray/binary conversion helpers for gray_counter   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Narrower values are zero-extended into a full word, which leaves the
  // low-order result bits identical to a WIDTH-bit conversion.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_conv.sv
// +--------------------------------------------------------------------+
// | gray_conv : combinational binary->Gray and Gray->binary converter   |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o
);

  assign gray_o = WIDTH'(bin2gray(gray_word_t'(bin_i)));
  assign bin_o  = WIDTH'(gray2bin(gray_word_t'(gray_i)));

endmodule

`default_nettype wire

// File: rtl/gray_counter.sv
// +--------------------------------------------------------------------+
// | gray_counter : registered binary/Gray counter with load and wrap    |
// |   Define GRAY_COUNTER_UPDOWN_EN to build the down-count path.      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] C_RST_GRAY = WIDTH'(bin2gray(gray_word_t'(RST_VAL)));
  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_load_gray_unused;
  logic [WIDTH-1:0] w_gray_q_bin_unused;

  gray_conv #(.WIDTH(WIDTH)) u_load_conv (
    .bin_i  (load_val),
    .gray_i (load_val),
    .gray_o (w_load_gray_unused),
    .bin_o  (w_load_bin)
  );

  // Gray register is derived from the same next-state value as bin_q.
  gray_conv #(.WIDTH(WIDTH)) u_next_conv (
    .bin_i  (bin_d),
    .gray_i (gray_q),
    .gray_o (gray_d),
    .bin_o  (w_gray_q_bin_unused)
  );

`ifndef GRAY_COUNTER_UPDOWN_EN
  logic w_dir_unused;
  assign w_dir_unused = dir;
`endif

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_is_gray ? w_load_bin : load_val;
    end else if (en) begin
`ifdef GRAY_COUNTER_UPDOWN_EN
      if (dir) begin
        bin_d  = bin_q + C_ONE;
        wrap_d = (bin_q == C_ALL_ONES);
      end else begin
        bin_d  = bin_q - C_ONE;
        wrap_d = (bin_q == '0);
      end
`else
      bin_d  = bin_q + C_ONE;
      wrap_d = (bin_q == C_ALL_ONES);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= C_RST_BIN;
      gray_q <= C_RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire
